// File: rtl/sequenciador_reproducao_pkg.sv
// Shared definitions for the playback controller: state encoding and word-rate divider math.
package sequenciador_reproducao_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    TOCANDO  = 2'd1,
    PAUSADO  = 2'd2,
    TROCANDO = 2'd3
  } estado_t;

  // Word rate shared with the address ASM, which measures song length in these words.
  localparam int TAXA_PALAVRAS = 3000;

  function automatic int calc_div(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

endpackage

// File: rtl/sequenciador_reproducao_divisor_tick.sv
// Modulo-DIV counter producing the sample tick; clear wins over enable, and it holds when neither is set.
module divisor_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] ULTIMO = W'(DIV - 1);

  logic [W-1:0] contador;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contador <= '0;
    end else if (clear) begin
      contador <= '0;
    end else if (enable) begin
      contador <= (contador == ULTIMO) ? '0 : contador + 1'b1;
    end
  end

  assign tick = enable && (contador == ULTIMO);

endmodule

// File: rtl/sequenciador_reproducao.sv
// Playback controller: play/pause/stop state, song index, sample tick and rewind pulses for the address ASM.
module sequenciador_reproducao
  import sequenciador_reproducao_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SAMPLE_HZ   = TAXA_PALAVRAS,
  parameter int NUM_MUSICAS = 4,
  parameter int MUSICA_BITS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play_pause,
  input  logic                   parar,
  input  logic                   proxima,
  input  logic                   anterior,
  input  logic                   repetir,
  input  logic                   prox_musica,
  output logic                   count,
  output logic                   reinicia,
  output logic [MUSICA_BITS-1:0] musica_atual,
  output logic                   tocando
);

  localparam int DIV = calc_div(CLK_HZ, SAMPLE_HZ);
  localparam logic [MUSICA_BITS-1:0] ULTIMA = MUSICA_BITS'(NUM_MUSICAS - 1);

  estado_t estado, estado_prox, retorno, retorno_prox;
  logic [MUSICA_BITS-1:0] musica_prox;
  logic play_pause_d, parar_d, proxima_d, anterior_d;
  logic ev_play_pause, ev_parar, ev_proxima, ev_anterior;
  logic em_reset, guarda, fim;

  function automatic logic [MUSICA_BITS-1:0] idx_seguinte(input logic [MUSICA_BITS-1:0] i);
    return (i == ULTIMA) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [MUSICA_BITS-1:0] idx_anterior(input logic [MUSICA_BITS-1:0] i);
    return (i == '0) ? ULTIMA : i - 1'b1;
  endfunction

  // em_reset keeps reinicia high through reset and drops it on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      play_pause_d <= 1'b0;
      parar_d      <= 1'b0;
      proxima_d    <= 1'b0;
      anterior_d   <= 1'b0;
      em_reset     <= 1'b1;
    end else begin
      play_pause_d <= play_pause;
      parar_d      <= parar;
      proxima_d    <= proxima;
      anterior_d   <= anterior;
      em_reset     <= 1'b0;
    end
  end

  assign ev_play_pause = play_pause & ~play_pause_d;
  assign ev_parar      = parar & ~parar_d;
  assign ev_proxima    = proxima & ~proxima_d;
  assign ev_anterior   = anterior & ~anterior_d;

  divisor_tick #(.DIV(DIV)) u_divisor_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (estado == TOCANDO),
    .clear  ((estado == PARADO) || (estado == TROCANDO)),
    .tick   (count)
  );

  assign fim = prox_musica & count & ~guarda;

  always_comb begin
    estado_prox  = estado;
    retorno_prox = retorno;
    musica_prox  = musica_atual;
    unique case (estado)
      PARADO: begin
        if (ev_parar) begin
          estado_prox = PARADO;
        end else if (ev_proxima) begin
          estado_prox  = TROCANDO;
          retorno_prox = PARADO;
          musica_prox  = idx_seguinte(musica_atual);
        end else if (ev_anterior) begin
          estado_prox  = TROCANDO;
          retorno_prox = PARADO;
          musica_prox  = idx_anterior(musica_atual);
        end else if (ev_play_pause) begin
          estado_prox = TOCANDO;
        end
      end
      TOCANDO: begin
        if (ev_parar) begin
          estado_prox  = TROCANDO;
          retorno_prox = PARADO;
        end else if (ev_proxima) begin
          estado_prox  = TROCANDO;
          retorno_prox = TOCANDO;
          musica_prox  = idx_seguinte(musica_atual);
        end else if (ev_anterior) begin
          estado_prox  = TROCANDO;
          retorno_prox = TOCANDO;
          musica_prox  = idx_anterior(musica_atual);
        end else if (ev_play_pause) begin
          estado_prox = PAUSADO;
        end else if (fim) begin
          estado_prox = TROCANDO;
          if ((musica_atual == ULTIMA) && !repetir) begin
            retorno_prox = PARADO;
            musica_prox  = '0;
          end else begin
            retorno_prox = TOCANDO;
            musica_prox  = idx_seguinte(musica_atual);
          end
        end
      end
      PAUSADO: begin
        if (ev_parar) begin
          estado_prox  = TROCANDO;
          retorno_prox = PARADO;
        end else if (ev_proxima) begin
          estado_prox  = TROCANDO;
          retorno_prox = PAUSADO;
          musica_prox  = idx_seguinte(musica_atual);
        end else if (ev_anterior) begin
          estado_prox  = TROCANDO;
          retorno_prox = PAUSADO;
          musica_prox  = idx_anterior(musica_atual);
        end else if (ev_play_pause) begin
          estado_prox = TOCANDO;
        end
      end
      TROCANDO: begin
        estado_prox = retorno;
      end
      default: estado_prox = PARADO;
    endcase
  end

  // guarda masks the first tick after a rewind, when the ASM may still report a stale end-of-song.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado       <= PARADO;
      retorno      <= PARADO;
      musica_atual <= '0;
      guarda       <= 1'b1;
    end else begin
      estado       <= estado_prox;
      retorno      <= retorno_prox;
      musica_atual <= musica_prox;
      if (estado == TROCANDO) begin
        guarda <= 1'b1;
      end else if (count) begin
        guarda <= 1'b0;
      end
    end
  end

  assign reinicia = em_reset | (estado == TROCANDO);
  assign tocando  = (estado == TOCANDO);

endmodule
